// File: rtl/subbytes_share_arb_pkg.sv
// Shared types and sizing for the SubBytes arbiter: FSM states, word index,
// datapath word width and the number of words in one AES state.
package subbytes_share_arb_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_STATE = 4;
  localparam int STATE_W         = WORD_W * WORDS_PER_STATE;

  typedef logic [$clog2(WORDS_PER_STATE)-1:0] word_idx_t;

  localparam word_idx_t LAST_WORD = word_idx_t'(WORDS_PER_STATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KS_RUN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/SubBytes_ny_3.sv
// Combinational 32-bit SubBytes: four independent AES forward S-boxes,
// one per byte lane.
module SubBytes_ny_3
  import subbytes_share_arb_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar i = 0; i < WORD_W / 8; i++) begin : g_lane
    assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
  end

endmodule

// File: rtl/subbytes_share_arb.sv
// Round-robin time-sharing of one 32-bit SubBytes datapath between a 128-bit
// state requester and a 32-bit SubWord requester. Optional: SB_ARB_KS_INTERLEAVE_EN.
module subbytes_share_arb
  import subbytes_share_arb_pkg::*;
#(
  parameter bit KS_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_req,
  input  logic [STATE_W-1:0] st_din,
  output logic               st_ack,
  output logic [STATE_W-1:0] st_dout,
  output logic               st_done,
  input  logic               ks_req,
  input  logic [WORD_W-1:0]  ks_din,
  output logic               ks_ack,
  output logic [WORD_W-1:0]  ks_dout,
  output logic               ks_done
);

  arb_state_t        state_q, state_d;
  word_idx_t         word_q;
  logic              prio_ks_q;
  logic [WORD_W-1:0] st_buf_q [WORDS_PER_STATE];
  logic [WORD_W-1:0] st_acc_q [WORDS_PER_STATE-1];
  logic [WORD_W-1:0] ks_buf_q;
  logic [WORD_W-1:0] sb_in, sb_out;
`ifdef SB_ARB_KS_INTERLEAVE_EN
  // Set while a SubWord has borrowed the datapath from the running state job.
  logic              ks_slot_q;
`endif

  SubBytes_ny_3 u_sbox (
    .din  (sb_in),
    .dout (sb_out)
  );

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    st_ack  = 1'b0;
    ks_ack  = 1'b0;
    sb_in   = '0;
    unique case (state_q)
      IDLE: begin
        if (st_req && !(ks_req && prio_ks_q)) begin
          st_ack  = 1'b1;
          state_d = ST_RUN;
        end else if (ks_req) begin
          ks_ack  = 1'b1;
          state_d = KS_RUN;
        end
      end
      ST_RUN: begin
        sb_in = st_buf_q[word_q];
        if (word_q == LAST_WORD) begin
          state_d = IDLE;
`ifdef SB_ARB_KS_INTERLEAVE_EN
        end else if (ks_req && !ks_slot_q) begin
          ks_ack  = 1'b1;
          state_d = KS_RUN;
`endif
        end
      end
      KS_RUN: begin
        sb_in = ks_buf_q;
`ifdef SB_ARB_KS_INTERLEAVE_EN
        state_d = ks_slot_q ? ST_RUN : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Strobes stay low while reset is held, even if requests are up.
    if (rst) begin
      st_ack = 1'b0;
      ks_ack = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      prio_ks_q <= KS_FIRST;
      ks_buf_q  <= '0;
      st_dout   <= '0;
      ks_dout   <= '0;
      st_done   <= 1'b0;
      ks_done   <= 1'b0;
      // NOTE: the operand and partial-result arrays are small register banks, not RAM, so they are cleared too.
      for (int i = 0; i < WORDS_PER_STATE; i++) st_buf_q[i] <= '0;
      for (int i = 0; i < WORDS_PER_STATE - 1; i++) st_acc_q[i] <= '0;
`ifdef SB_ARB_KS_INTERLEAVE_EN
      ks_slot_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      st_done <= 1'b0;
      ks_done <= 1'b0;

      if (st_ack) begin
        for (int i = 0; i < WORDS_PER_STATE; i++) st_buf_q[i] <= st_din[i*WORD_W +: WORD_W];
        word_q    <= '0;
        prio_ks_q <= 1'b1;
`ifdef SB_ARB_KS_INTERLEAVE_EN
        ks_slot_q <= 1'b0;
`endif
      end

      if (ks_ack) begin
        ks_buf_q  <= ks_din;
        prio_ks_q <= 1'b0;
`ifdef SB_ARB_KS_INTERLEAVE_EN
        ks_slot_q <= (state_q == ST_RUN);
`endif
      end

      // Partial words collect in st_acc_q so st_dout moves only on the last word.
      if (state_q == ST_RUN) begin
        word_q <= word_q + word_idx_t'(1);
        if (word_q == LAST_WORD) begin
          for (int i = 0; i < WORDS_PER_STATE - 1; i++) st_dout[i*WORD_W +: WORD_W] <= st_acc_q[i];
          st_dout[STATE_W-1 -: WORD_W] <= sb_out;
          st_done <= 1'b1;
        end else begin
          st_acc_q[word_q] <= sb_out;
        end
      end

      if (state_q == KS_RUN) begin
        ks_dout <= sb_out;
        ks_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_subbytes_share_arb.sv
// Self-checking bench for subbytes_share_arb: S-box reference built from GF(2^8)
// inversion plus the affine map, and a transaction-level arbitration model.
module tb_subbytes_share_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         st_req, st_ack, st_done;
  logic [127:0] st_din, st_dout;
  logic         ks_req, ks_ack, ks_done;
  logic [31:0]  ks_din, ks_dout;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_st_hold;
  logic [31:0]  exp_ks_hold;

  subbytes_share_arb #(.KS_FIRST(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .st_req  (st_req),
    .st_din  (st_din),
    .st_ack  (st_ack),
    .st_dout (st_dout),
    .st_done (st_done),
    .ks_req  (ks_req),
    .ks_din  (ks_din),
    .ks_ack  (ks_ack),
    .ks_dout (ks_dout),
    .ks_done (ks_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_ref(w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = sub_word(s[32*i +: 32]);
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    st_req = 1'b0;
    ks_req = 1'b0;
    st_din = '0;
    ks_din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_st_hold = '0;
    exp_ks_hold = '0;
  endtask

  // One state job on an idle DUT: ack at c0, st_done at c5, result held otherwise.
  task automatic st_job(input logic [127:0] d, input string tag);
    logic [127:0] exp_v;
    logic [3:0]   got, want;
    exp_v  = sub_state(d);
    st_din = d;
    st_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      want = (c == 0) ? 4'b1000 : (c == 5) ? 4'b0010 : 4'b0000;
      got  = {st_ack, ks_ack, st_done, ks_done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s strobes c%0d: got %b expected %b", tag, c, got, want);
      end
      if (c == 5) exp_st_hold = exp_v;
      checks++;
      if (st_dout !== exp_st_hold) begin
        errors++;
        $display("FAIL %s st_dout c%0d: got %h expected %h", tag, c, st_dout, exp_st_hold);
      end
      step();
      st_req = 1'b0;
      st_din = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // One SubWord job on an idle DUT: ack at c0, ks_done at c2.
  task automatic ks_job(input logic [31:0] d, input string tag);
    logic [31:0] exp_v;
    logic [3:0]  got, want;
    exp_v  = sub_word(d);
    ks_din = d;
    ks_req = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      want = (c == 0) ? 4'b0100 : (c == 2) ? 4'b0001 : 4'b0000;
      got  = {st_ack, ks_ack, st_done, ks_done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s strobes c%0d: got %b expected %b", tag, c, got, want);
      end
      if (c == 2) exp_ks_hold = exp_v;
      checks++;
      if (ks_dout !== exp_ks_hold) begin
        errors++;
        $display("FAIL %s ks_dout c%0d: got %h expected %h", tag, c, ks_dout, exp_ks_hold);
      end
      step();
      ks_req = 1'b0;
      ks_din = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst    = 1'b1;
    st_req = 1'b1;
    ks_req = 1'b1;
    st_din = '1;
    ks_din = '1;
    #2;
    checks++;
    if ({st_ack, ks_ack, st_done, ks_done} !== 4'b0000 || st_dout !== '0 || ks_dout !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got strobes %b st_dout %h ks_dout %h expected all zero",
               {st_ack, ks_ack, st_done, ks_done}, st_dout, ks_dout);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({st_ack, ks_ack, st_done, ks_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle_strobes: got %b expected 0000", {st_ack, ks_ack, st_done, ks_done});
    end
    step();
  endtask

  task automatic test_vectors();
    st_job('0, "st_zero");
    checks++;
    if (st_dout !== {16{8'h63}}) begin
      errors++;
      $display("FAIL st_zero_const: got %h expected %h", st_dout, {16{8'h63}});
    end
    ks_job(32'h01020304, "ks_01020304");
    checks++;
    if (ks_dout !== 32'h7C777BF2) begin
      errors++;
      $display("FAIL ks_const: got %h expected 7c777bf2", ks_dout);
    end
  endtask

  task automatic test_random_single();
    repeat (4) st_job({$urandom, $urandom, $urandom, $urandom}, "st_rand");
    repeat (4) ks_job($urandom, "ks_rand");
  endtask

  // Both request together after reset: ks wins, state acked in the ks_done cycle
  // while ks re-requests, then ks waits for the state job to finish.
  task automatic test_contention();
    logic [3:0]   want, got;
    logic [127:0] st_op;
    logic [31:0]  ks_op0, ks_op1;
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      st_req = (c <= 2);
      ks_req = (c == 0) || (c >= 2 && c <= 7);
      st_din = {$urandom, $urandom, $urandom, $urandom};
      ks_din = $urandom;
      if (c == 0) ks_op0 = ks_din;
      if (c == 2) st_op  = st_din;
      if (c == 7) ks_op1 = ks_din;
      @(negedge clk);
      case (c)
        0:       want = 4'b0100;
        2:       want = 4'b1001;
        7:       want = 4'b0110;
        9:       want = 4'b0001;
        default: want = 4'b0000;
      endcase
      got = {st_ack, ks_ack, st_done, ks_done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL contention strobes c%0d: got %b expected %b", c, got, want);
      end
      if (c == 2) begin
        checks++;
        if (ks_dout !== sub_word(ks_op0)) begin
          errors++;
          $display("FAIL contention ks_first: got %h expected %h", ks_dout, sub_word(ks_op0));
        end
      end
      if (c == 7) begin
        checks++;
        if (st_dout !== sub_state(st_op)) begin
          errors++;
          $display("FAIL contention st_second: got %h expected %h", st_dout, sub_state(st_op));
        end
      end
      if (c == 9) begin
        checks++;
        if (ks_dout !== sub_word(ks_op1)) begin
          errors++;
          $display("FAIL contention ks_third: got %h expected %h", ks_dout, sub_word(ks_op1));
        end
      end
      step();
    end
    st_req = 1'b0;
    ks_req = 1'b0;
  endtask

`ifndef SB_ARB_KS_INTERLEAVE_EN
  // Random request traffic against a job-level model: whoever is idle-granted
  // occupies the datapath for 4 (state) or 1 (key) cycles; ties go round-robin.
  task automatic test_random_mix();
    int           busy, st_due, ks_due;
    bit           prio_ks, st_pend, ks_pend, e_sa, e_ka, e_sd, e_kd;
    logic [127:0] st_next;
    logic [31:0]  ks_next;
    logic [3:0]   want, got;
    do_reset();
    busy = 0; prio_ks = 1'b1; st_due = -1; ks_due = -1;
    st_pend = 1'b0; ks_pend = 1'b0;
    st_next = '0; ks_next = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!st_pend && $urandom_range(0, 2) == 0) st_pend = 1'b1;
      if (!ks_pend && $urandom_range(0, 2) == 0) ks_pend = 1'b1;
      st_req = st_pend;
      ks_req = ks_pend;
      st_din = {$urandom, $urandom, $urandom, $urandom};
      ks_din = $urandom;
      @(negedge clk);
      e_sa = (busy == 0) && st_req && !(ks_req && prio_ks);
      e_ka = (busy == 0) && ks_req && !e_sa;
      e_sd = (cyc == st_due);
      e_kd = (cyc == ks_due);
      if (e_sd) exp_st_hold = st_next;
      if (e_kd) exp_ks_hold = ks_next;
      want = {e_sa, e_ka, e_sd, e_kd};
      got  = {st_ack, ks_ack, st_done, ks_done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mix strobes cyc%0d: got %b expected %b", cyc, got, want);
      end
      checks++;
      if (st_dout !== exp_st_hold || ks_dout !== exp_ks_hold) begin
        errors++;
        $display("FAIL mix douts cyc%0d: got %h/%h expected %h/%h", cyc, st_dout, ks_dout, exp_st_hold, exp_ks_hold);
      end
      if (e_sa) begin
        busy = 4; prio_ks = 1'b1; st_due = cyc + 5; st_next = sub_state(st_din); st_pend = 1'b0;
      end else if (e_ka) begin
        busy = 1; prio_ks = 1'b0; ks_due = cyc + 2; ks_next = sub_word(ks_din); ks_pend = 1'b0;
      end else if (busy > 0) begin
        busy--;
      end
      step();
    end
    st_req = 1'b0;
    ks_req = 1'b0;
  endtask
`endif

  // ks_req raised while the state job works on word 1.
  task automatic test_interleave();
    logic [3:0]   want, got;
    logic [127:0] st_op;
    logic [31:0]  ks_op;
    int           ks_ack_c, ks_done_c, st_done_c;
`ifdef SB_ARB_KS_INTERLEAVE_EN
    ks_ack_c = 2; ks_done_c = 4; st_done_c = 6;
`else
    ks_ack_c = 5; ks_done_c = 7; st_done_c = 5;
`endif
    do_reset();
    ks_op = '0;
    for (int c = 0; c <= 8; c++) begin
      st_req = (c == 0);
      ks_req = (c >= 2 && c <= ks_ack_c);
      st_din = {$urandom, $urandom, $urandom, $urandom};
      ks_din = $urandom;
      if (c == 0) st_op = st_din;
      if (c == ks_ack_c) ks_op = ks_din;
      @(negedge clk);
      want = {c == 0, c == ks_ack_c, c == st_done_c, c == ks_done_c};
      got  = {st_ack, ks_ack, st_done, ks_done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL interleave strobes c%0d: got %b expected %b", c, got, want);
      end
      if (c == st_done_c) begin
        checks++;
        if (st_dout !== sub_state(st_op)) begin
          errors++;
          $display("FAIL interleave st_dout: got %h expected %h", st_dout, sub_state(st_op));
        end
      end
      if (c == ks_done_c) begin
        checks++;
        if (ks_dout !== sub_word(ks_op)) begin
          errors++;
          $display("FAIL interleave ks_dout: got %h expected %h", ks_dout, sub_word(ks_op));
        end
      end
      step();
    end
    st_req = 1'b0;
    ks_req = 1'b0;
  endtask

  // Reset lands while the state job is on word 2: everything clears at once and
  // the aborted job never reports done.
  task automatic test_reset_abort();
    do_reset();
    st_job({$urandom, $urandom, $urandom, $urandom}, "st_pre_abort");
    ks_job($urandom, "ks_pre_abort");
    st_din = {$urandom, $urandom, $urandom, $urandom};
    st_req = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ack !== 1'b1) begin
      errors++;
      $display("FAIL abort_ack: got %b expected 1", st_ack);
    end
    step();
    st_req = 1'b0;
    step();
    step();
    #2;
    rst    = 1'b1;
    st_req = 1'b1;
    ks_req = 1'b1;
    #1;
    checks++;
    if ({st_ack, ks_ack, st_done, ks_done} !== 4'b0000 || st_dout !== '0 || ks_dout !== '0) begin
      errors++;
      $display("FAIL abort_async_clear: got strobes %b st_dout %h ks_dout %h expected all zero",
               {st_ack, ks_ack, st_done, ks_done}, st_dout, ks_dout);
    end
    @(posedge clk);
    step();
    st_req = 1'b0;
    ks_req = 1'b0;
    rst    = 1'b0;
    exp_st_hold = '0;
    exp_ks_hold = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({st_ack, ks_ack, st_done, ks_done} !== 4'b0000 || st_dout !== '0) begin
        errors++;
        $display("FAIL abort_no_done c%0d: got strobes %b st_dout %h expected 0000 and zero",
                 c, {st_ack, ks_ack, st_done, ks_done}, st_dout);
      end
      step();
    end
    st_job({16{8'h53}}, "st_53");
    checks++;
    if (st_dout !== {16{8'hed}}) begin
      errors++;
      $display("FAIL st_53_const: got %h expected %h", st_dout, {16{8'hed}});
    end
  endtask

  initial begin
    rst    = 1'b1;
    st_req = 1'b0;
    ks_req = 1'b0;
    st_din = '0;
    ks_din = '0;
    test_reset();
    test_vectors();
    test_random_single();
    test_contention();
`ifndef SB_ARB_KS_INTERLEAVE_EN
    test_random_mix();
`endif
    test_interleave();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subbytes_share_arb.md
SUBBYTES_SHARE_ARB -- requirements
Module: subbytes_share_arb

Interface
REQ-001 SHALL have parameter KS_FIRST, default 1: tie-break at reset or first contention; 1 = key-schedule wins, 0 = state wins.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port st_req, input, 1: state requester wants a 128-bit SubBytes pass; held until st_ack.
REQ-005 SHALL have port st_din, input, 128: state operand, sampled only in the st_ack cycle; word k = bits 32k+31:32k.
REQ-006 SHALL have port st_ack, output, 1: combinational accept strobe for st_req.
REQ-007 SHALL have port st_dout, output, 128: substituted state, held until next state job completes.
REQ-008 SHALL have port st_done, output, 1: one-cycle pulse, st_dout valid.
REQ-009 SHALL have port ks_req, input, 1: key-schedule requester wants SubWord; held until ks_ack.
REQ-010 SHALL have port ks_din, input, 32: SubWord operand, sampled only in the ks_ack cycle.
REQ-011 SHALL have port ks_ack, output, 1: combinational accept strobe for ks_req.
REQ-012 SHALL have port ks_dout, output, 32: substituted word, held until next key-schedule job completes.
REQ-013 SHALL have port ks_done, output, 1: one-cycle pulse, ks_dout valid.

Function
REQ-014 SHALL time-share exactly one 32-bit SubBytes datapath (four byte S-boxes) between both requesters.
REQ-015 SHALL implement FSM states IDLE, ST_RUN, KS_RUN; rst forces IDLE.
REQ-016 IDLE, one request: SHALL accept it (ack high that cycle), capture operand, go ST_RUN (word counter = 0) or KS_RUN.
REQ-017 IDLE, both requests: SHALL grant the requester not served last (round-robin flag); flag at reset per KS_FIRST.
REQ-018 ST_RUN: SHALL drive word counter k (0..3) into the datapath each cycle, capture result into st_dout word k; after k = 3 go IDLE.
REQ-019 KS_RUN: SHALL drive captured ks operand for one cycle, capture into ks_dout, go IDLE.
REQ-020 Latency: accept edge E0; st_done high in cycle after E4; ks_done high in cycle after E1.
REQ-021 New acceptance SHALL be possible in the same cycle a done pulse is high (back-to-back, no bubble beyond IDLE cycle).
REQ-022 Requests arriving while busy SHALL wait; ack never asserted outside IDLE (except REQ-027).
REQ-023 st_dout/ks_dout SHALL only change on their final capture edge; partial state words never visible with st_done high.
REQ-024 Acks and dones SHALL never be high for a requester without a corresponding request/job.

Reset
REQ-025 rst SHALL asynchronously clear FSM, counter, operand buffers, st_dout, ks_dout, st_done, ks_done to 0; round-robin flag to KS_FIRST.
REQ-026 rst mid-job SHALL abort it with no done pulse; request must be re-presented after release.

Configuration
REQ-027 With SB_ARB_KS_INTERLEAVE_EN defined: ks_req pending in ST_RUN SHALL be acked at a word boundary, given the datapath for one cycle (counter paused), ks_done next cycle; st_done delayed 1 cycle; max one insertion per state job. Without it: ks_req waits for IDLE.

Structure
REQ-028 Shared package SHALL hold FSM state enum, word-index type, word width (32) and words-per-state (4) constants.
REQ-029 SHALL instantiate one SubBytes_ny_3 as its sole sub-module; no other S-box logic.

Verification
REQ-030 st_din = all 0x00 -> st_done cycle after E4, st_dout = 0x63 repeated 16 bytes.
REQ-031 ks_din = 0x01020304 -> ks_done cycle after E1, ks_dout = 0x7C777BF2.
REQ-032 Both requests in same IDLE cycle, KS_FIRST = 1 -> ks served first, state acked in cycle ks_done is high; repeat -> state served first.
REQ-033 rst asserted during ST_RUN k = 2 -> all outputs 0 immediately, no st_done; new st_din = 0x53 bytes -> st_dout = 0xED bytes.
REQ-034 With SB_ARB_KS_INTERLEAVE_EN, ks_req raised at ST_RUN k = 1 -> ks_done within 2 cycles, st_done one cycle later than REQ-020, st_dout correct.
